// File: rtl/alu_pkg.sv
// Shared constants, state/op-class types and funct decode for the multi-cycle ALU.
// Optional MULTU support is built when ALU_MC_MULT_EN is defined.
package alu_pkg;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
`ifdef ALU_MC_MULT_EN
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StShift
`ifdef ALU_MC_MULT_EN
        , StMul
`endif
    } state_e;

    typedef enum logic [1:0] {OpExec, OpShift, OpMul} op_class_e;

    typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

    // Anything not routed to SHIFT/MUL goes through EXEC, which flags unknown functs.
    function automatic op_class_e decode_op(input logic [5:0] funct);
        case (funct)
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: return OpShift;
`ifdef ALU_MC_MULT_EN
            FUNCT_MULTU:                     return OpMul;
`endif
            default:                         return OpExec;
        endcase
    endfunction

    function automatic shift_e shift_kind(input logic [5:0] funct);
        case (funct)
            FUNCT_SRL: return ShSrl;
            FUNCT_SRA: return ShSra;
            default:   return ShSll;
        endcase
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle between an ALU client (master) and alu_mc (slave).
interface alu_mc_if #(
    parameter int unsigned W   = 32,
    parameter int unsigned SAW = $clog2(W)
) ();
    logic [5:0]     funct;
    logic           alu_enable;
    logic [W-1:0]   rs_val;
    logic [W-1:0]   rt_val;
    logic [SAW-1:0] sa;
    logic [W-1:0]   rd_val;
    logic           alu_valid;
    logic           alu_busy;
    logic           ovf;
    logic           illegal;

    modport master (
        output funct, alu_enable, rs_val, rt_val, sa,
        input  rd_val, alu_valid, alu_busy, ovf, illegal
    );

    modport slave (
        input  funct, alu_enable, rs_val, rt_val, sa,
        output rd_val, alu_valid, alu_busy, ovf, illegal
    );
endinterface

// File: rtl/alu_shifter.sv
// One-bit-per-step shifter: load latches operand, amount and direction; dout is the
// value after the current step, done flags that the current step is the last.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned SAW = $clog2(W)
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic           load,
    input  logic           step,
    input  shift_e         kind,
    input  logic [W-1:0]   din,
    input  logic [SAW-1:0] amt,
    output logic [W-1:0]   dout,
    output logic           done
);
    logic [W-1:0]   data_q;
    logic [W-1:0]   one_step;
    logic [SAW-1:0] cnt_q;
    shift_e         kind_q;

    always_comb begin
        one_step = data_q;
        case (kind_q)
            ShSll:   one_step = {data_q[W-2:0], 1'b0};
            ShSrl:   one_step = {1'b0, data_q[W-1:1]};
            ShSra:   one_step = {data_q[W-1], data_q[W-1:1]};
            default: one_step = data_q;
        endcase
    end

    // A zero amount finishes on the first step with the operand unchanged.
    assign dout = (cnt_q == '0) ? data_q : one_step;
    assign done = (cnt_q <= SAW'(1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            data_q <= '0;
            cnt_q  <= '0;
            kind_q <= ShSll;
        end else if (load) begin
            data_q <= din;
            cnt_q  <= amt;
            kind_q <= kind;
        end else if (step && (cnt_q != '0)) begin
            data_q <= one_step;
            cnt_q  <= cnt_q - SAW'(1);
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS R-type ALU: IDLE/EXEC/SHIFT FSM with registered outputs.
// Defining ALU_MC_MULT_EN adds an iterative MULTU in an extra MUL state.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned SAW = $clog2(W)
) (
    input logic     CLK,
    input logic     RSTN,
    alu_mc_if.slave bus
);
    state_e       state_q;
    logic [5:0]   funct_q;
    logic [W-1:0] rs_q, rt_q;
    logic [W-1:0] rd_q;
    logic         valid_q, busy_q, ovf_q, illegal_q;

    op_class_e    cls;
    shift_e       sh_kind;
    logic         sh_load, sh_step, sh_done;
    logic [W-1:0] sh_out;

    logic [W-1:0] sum, diff, exec_res;
    logic         exec_ovf, exec_ill;

    assign cls     = decode_op(bus.funct);
    assign sh_kind = shift_kind(bus.funct);
    assign sh_load = (state_q == StIdle) && bus.alu_enable && (cls == OpShift);
    assign sh_step = (state_q == StShift);

    alu_shifter #(.W(W), .SAW(SAW)) u_shifter (
        .CLK  (CLK),
        .RSTN (RSTN),
        .load (sh_load),
        .step (sh_step),
        .kind (sh_kind),
        .din  (bus.rt_val),
        .amt  (bus.sa),
        .dout (sh_out),
        .done (sh_done)
    );

    always_comb begin
        sum      = rs_q + rt_q;
        diff     = rs_q - rt_q;
        exec_res = '0;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (funct_q)
            FUNCT_ADD: begin
                exec_res = sum;
                exec_ovf = (rs_q[W-1] == rt_q[W-1]) && (sum[W-1] != rs_q[W-1]);
            end
            FUNCT_SUB: begin
                exec_res = diff;
                exec_ovf = (rs_q[W-1] != rt_q[W-1]) && (diff[W-1] != rs_q[W-1]);
            end
            FUNCT_AND: exec_res = rs_q & rt_q;
            FUNCT_OR:  exec_res = rs_q | rt_q;
            FUNCT_XOR: exec_res = rs_q ^ rt_q;
            FUNCT_SLT: exec_res = {{(W-1){1'b0}}, ($signed(rs_q) < $signed(rt_q))};
            FUNCT_JR:  exec_res = rs_q;
            default:   exec_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_MULT_EN
    // Shift-add multiplier: low half starts as rt and is consumed LSB-first.
    logic [2*W-1:0] prod_q, prod_nxt;
    logic [SAW-1:0] mcnt_q;
    logic [W:0]     psum;

    always_comb begin
        psum     = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? rs_q : {W{1'b0}})};
        prod_nxt = {psum, prod_q[W-1:1]};
    end
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= StIdle;
            funct_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_MC_MULT_EN
            prod_q    <= '0;
            mcnt_q    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.alu_enable) begin
                        funct_q <= bus.funct;
                        rs_q    <= bus.rs_val;
                        rt_q    <= bus.rt_val;
                        busy_q  <= 1'b1;
                        case (cls)
                            OpShift: state_q <= StShift;
`ifdef ALU_MC_MULT_EN
                            OpMul: begin
                                state_q <= StMul;
                                prod_q  <= {{W{1'b0}}, bus.rt_val};
                                mcnt_q  <= SAW'(W - 1);
                            end
`endif
                            default: state_q <= StExec;
                        endcase
                    end
                end
                StExec: begin
                    rd_q      <= exec_res;
                    ovf_q     <= exec_ovf;
                    illegal_q <= exec_ill;
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                StShift: begin
                    if (sh_done) begin
                        rd_q      <= sh_out;
                        ovf_q     <= 1'b0;
                        illegal_q <= 1'b0;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
`ifdef ALU_MC_MULT_EN
                StMul: begin
                    prod_q <= prod_nxt;
                    mcnt_q <= mcnt_q - SAW'(1);
                    if (mcnt_q == '0) begin
                        rd_q      <= prod_nxt[W-1:0];
                        ovf_q     <= |prod_nxt[2*W-1:W];
                        illegal_q <= 1'b0;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rd_val    = rd_q;
    assign bus.alu_valid = valid_q;
    assign bus.alu_busy  = busy_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (W=32); inputs driven and outputs
// sampled on the falling clock edge.
module tb_alu_mc;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_mc_if #(.W(32)) bus ();

    alu_mc #(.W(32)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request at the current falling edge; returns after the accepting edge.
    task automatic start_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [4:0] s);
        bus.funct      = f;
        bus.rs_val     = rs;
        bus.rt_val     = rt;
        bus.sa         = s;
        bus.alu_enable = 1'b1;
        @(negedge clk);
        bus.alu_enable = 1'b0;
    endtask

    // Count falling edges until alu_valid, noting whether busy held high beforehand.
    task automatic wait_valid(input int max, output int n, output logic busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (n < max) begin
            if (!bus.alu_busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
            if (bus.alu_valid) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [4:0] s, input logic [31:0] exp_rd,
                          input logic exp_ovf, input logic exp_ill, input int exp_n);
        int   n;
        logic busy_ok;
        start_op(f, rs, rt, s);
        wait_valid(exp_n + 4, n, busy_ok);
        chk({tag, ".latency"}, 64'(n), 64'(exp_n));
        chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
        chk({tag, ".rd"}, 64'(bus.rd_val), 64'(exp_rd));
        chk({tag, ".ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        chk({tag, ".illegal"}, 64'(bus.illegal), 64'(exp_ill));
        @(negedge clk);
        chk({tag, ".pulse"}, 64'(bus.alu_valid), 64'd0);
        chk({tag, ".hold"}, 64'(bus.rd_val), 64'(exp_rd));
    endtask

    initial begin
        int   n;
        logic busy_ok;
        bus.funct      = '0;
        bus.rs_val     = '0;
        bus.rt_val     = '0;
        bus.sa         = '0;
        bus.alu_enable = 1'b0;

        #2;
        chk("reset.rd", 64'(bus.rd_val), 64'd0);
        chk("reset.valid", 64'(bus.alu_valid), 64'd0);
        chk("reset.busy", 64'(bus.alu_busy), 64'd0);
        chk("reset.ovf", 64'(bus.ovf), 64'd0);
        chk("reset.illegal", 64'(bus.illegal), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_op("add_ovf", 6'b100000, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1);
        run_op("add", 6'b100000, 32'd7, 32'd9, 5'd0, 32'd16, 1'b0, 1'b0, 1);
        run_op("sub_ovf", 6'b100010, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run_op("sub", 6'b100010, 32'd5, 32'd3, 5'd0, 32'd2, 1'b0, 1'b0, 1);
        run_op("and", 6'b100100, 32'hF0F0, 32'h0FF0, 5'd0, 32'h00F0, 1'b0, 1'b0, 1);
        run_op("or", 6'b100101, 32'hF0F0, 32'h0FF0, 5'd0, 32'hFFF0, 1'b0, 1'b0, 1);
        run_op("slt_neg", 6'b101010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'd1, 1'b0, 1'b0, 1);
        run_op("slt_swap", 6'b101010, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0, 1'b0, 1);
        run_op("sra4", 6'b000011, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 4);
        run_op("sra0", 6'b000011, 32'h0, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1);
        run_op("srl4", 6'b000010, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 4);
        run_op("sll3", 6'b000000, 32'h0, 32'h0000_0011, 5'd3, 32'h0000_0088, 1'b0, 1'b0, 3);

        // SLL by 31 with enable held; the request is swapped for an ADD while busy.
        bus.funct      = 6'b000000;
        bus.rt_val     = 32'h1;
        bus.sa         = 5'd31;
        bus.alu_enable = 1'b1;
        @(negedge clk);
        bus.funct  = 6'b100000;
        bus.rs_val = 32'd2;
        bus.rt_val = 32'd3;
        bus.sa     = 5'd0;
        wait_valid(40, n, busy_ok);
        chk("sll31.latency", 64'(n), 64'd31);
        chk("sll31.busy", 64'(busy_ok), 64'd1);
        chk("sll31.rd", 64'(bus.rd_val), 64'h8000_0000);
        @(negedge clk);
        chk("b2b.pulse", 64'(bus.alu_valid), 64'd0);
        chk("b2b.accepted", 64'(bus.alu_busy), 64'd1);
        bus.alu_enable = 1'b0;
        @(negedge clk);
        chk("b2b.valid", 64'(bus.alu_valid), 64'd1);
        chk("b2b.rd", 64'(bus.rd_val), 64'd5);
        @(negedge clk);

        // Reset in the middle of a long shift.
        start_op(6'b000000, 32'h0, 32'h1, 5'd20);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst.rd", 64'(bus.rd_val), 64'd0);
        chk("midrst.busy", 64'(bus.alu_busy), 64'd0);
        chk("midrst.valid", 64'(bus.alu_valid), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst.discard", 64'(bus.alu_valid), 64'd0);
        chk("midrst.idle", 64'(bus.alu_busy), 64'd0);
        run_op("xor", 6'b100110, 32'hF0F0, 32'h0FF0, 5'd0, 32'hFF00, 1'b0, 1'b0, 1);

        run_op("illegal", 6'b111111, 32'h1234, 32'h5678, 5'd0, 32'd0, 1'b0, 1'b1, 1);
`ifdef ALU_MC_MULT_EN
        run_op("multu", 6'b011001, 32'd3, 32'd5, 5'd0, 32'd15, 1'b0, 1'b0, 32);
        run_op("multu_hi", 6'b011001, 32'h1_0000, 32'h1_0000, 5'd0, 32'd0, 1'b1, 1'b0, 32);
`else
        run_op("multu", 6'b011001, 32'd3, 32'd5, 5'd0, 32'd0, 1'b0, 1'b1, 1);
`endif
        run_op("jr", 6'b001000, 32'h1234_5678, 32'h0, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
